// File: rtl/uart_tx.sv
// 9-bit UART transmitter: start bit, nine data bits LSB first, stop bit(s), with a
// one-word holding register. Define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx #(
   parameter int CLK_HZ    = 25000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       send,
   input  logic [8:0] data,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam int DIV   = CLK_HZ / BAUD_RATE;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]       state, state_d;
   logic [8:0]       hold;
   logic             hold_valid;
   logic [8:0]       shift, shift_d;
   logic [3:0]       bit_cnt, bit_cnt_d;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
   logic             tx_d;
   logic             take_hold;
   logic             baud_last;
   logic             stop_last;

   assign baud_last = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_TWO_STOP_EN
   // Toggles at the end of each stop bit; set means the second stop bit is on the line.
   logic stop_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stop_cnt <= 1'b0;
      else if (state == STOP && baud_last)
         stop_cnt <= ~stop_cnt;
   end

   assign stop_last = stop_cnt;
`else
   assign stop_last = 1'b1;
`endif

   // NOTE: every always_comb output gets a default first, otherwise paths that
   // skip an assignment would infer a latch.
   always_comb begin
      state_d    = state;
      shift_d    = shift;
      bit_cnt_d  = bit_cnt;
      baud_cnt_d = baud_last ? '0 : baud_cnt + 1'b1;
      take_hold  = 1'b0;

      case (state)
         IDLE: begin
            baud_cnt_d = '0;
            if (hold_valid) begin
               state_d   = START;
               shift_d   = hold;
               bit_cnt_d = '0;
               take_hold = 1'b1;
            end
         end
         START: begin
            if (baud_last)
               state_d = DATA;
         end
         DATA: begin
            if (baud_last) begin
               shift_d = {1'b0, shift[8:1]};
               if (bit_cnt == 4'd8) begin
                  state_d   = STOP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt + 4'd1;
               end
            end
         end
         STOP: begin
            // A queued word chains straight into the next start bit with no idle gap.
            if (baud_last && stop_last) begin
               if (hold_valid) begin
                  state_d   = START;
                  shift_d   = hold;
                  bit_cnt_d = '0;
                  take_hold = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_d;
         shift    <= shift_d;
         bit_cnt  <= bit_cnt_d;
         baud_cnt <= baud_cnt_d;
         tx       <= tx_d;
      end
   end

   // NOTE: the holding data register is reset along with its valid flag; it is a
   // single word, so the reset costs nothing and keeps every state deterministic.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else if (take_hold) begin
         hold_valid <= 1'b0;
      end else if (send && !hold_valid) begin
         hold       <= data;
         hold_valid <= 1'b1;
      end
   end

   assign ready = !hold_valid;
   assign busy  = (state != IDLE);
   assign done  = (state == STOP) && baud_last && stop_last;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected words, a monitor decodes the
// line cycle by cycle. Honours UART_TX_TWO_STOP_EN for the expected stop length.
module tb_uart_tx;

   localparam int CLK_HZ    = 16;
   localparam int BAUD_RATE = 1;
   localparam int DIV       = 16;
`ifdef UART_TX_TWO_STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif
   localparam int FRAME   = (10 + STOP_BITS) * DIV;
   localparam int BIG_DIV = 2604;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       send;
   logic [8:0] data;
   logic       ready, busy, done, tx;

   logic       big_send;
   logic [8:0] big_data;
   logic       big_ready, big_busy, big_done, big_tx;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int frames_ok = 0;

   logic [8:0] exp_q[$];
   int         start_cyc[$];
   int         done_cyc[$];

   uart_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD_RATE)) u_dut (
      .clock(clock), .reset_n(reset_n), .send(send), .data(data),
      .ready(ready), .busy(busy), .done(done), .tx(tx)
   );

   uart_tx #(.CLK_HZ(25000000), .BAUD_RATE(9600)) u_dut_big (
      .clock(clock), .reset_n(reset_n), .send(big_send), .data(big_data),
      .ready(big_ready), .busy(big_busy), .done(big_done), .tx(big_tx)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: decodes every frame on tx and compares it with the next queued word.
   initial begin : monitor
      logic [8:0]  exp_w, got_w;
      logic [11:0] frame_bits;
      int          bit_err, busy_err, done_err, slot;
      bit          expected_frame, aborted;
      forever begin
         @(negedge clock);
         if (reset_n !== 1'b1) continue;
         if (done === 1'b1) check("stray_done", 32'(done), 0);
         if (tx === 1'b0) begin
            expected_frame = (exp_q.size() != 0);
            if (expected_frame) begin
               exp_w = exp_q.pop_front();
            end else begin
               check("frame_expected", 32'(exp_q.size()), 1);
               exp_w = '0;
            end
            frame_bits = {2'b11, exp_w, 1'b0};
            start_cyc.push_back(cyc);
            bit_err = 0; busy_err = 0; done_err = 0; got_w = '0; aborted = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
               if (i != 0) @(negedge clock);
               if (reset_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               slot = i / DIV;
               if (tx !== frame_bits[slot]) bit_err++;
               if (busy !== 1'b1) busy_err++;
               if (done !== (i == FRAME - 1)) done_err++;
               if ((i % DIV) == DIV / 2 && slot >= 1 && slot <= 9) got_w[slot-1] = tx;
            end
            if (!aborted) begin
               done_cyc.push_back(cyc);
               frames_ok++;
               if (expected_frame) begin
                  check("frame_word", 32'(got_w), 32'(exp_w));
                  check("frame_bit_cycles", 32'(bit_err), 0);
                  check("frame_busy", 32'(busy_err), 0);
                  check("frame_done_pos", 32'(done_err), 0);
               end
            end
         end
      end
   end

   task automatic wait_ready(input int budget);
      int n = 0;
      while (ready !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (ready !== 1'b1) check("ready_timeout", 32'(ready), 1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || ready !== 1'b1) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (busy !== 1'b0) check("idle_timeout", 32'(busy), 0);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [8:0] w);
      wait_ready(4 * FRAME);
      send = 1'b1;
      data = w;
      @(posedge clock);
      exp_q.push_back(w);
      #1;
      send = 1'b0;
      check("ready_drop", 32'(ready), 0);
      @(negedge clock);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      int snap, len, k;
      logic v;
      reset_n = 1'b0; send = 1'b0; data = '0; big_send = 1'b0; big_data = '0;
      repeat (3) @(negedge clock);
      check("rst_tx", 32'(tx), 1);
      check("rst_ready", 32'(ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("post_rst_tx", 32'(tx), 1);
      check("post_rst_busy", 32'(busy), 0);

      // Single frame with acceptance timing
      start_cyc.delete(); done_cyc.delete();
      send = 1'b1; data = 9'h155;
      @(posedge clock);
      exp_q.push_back(9'h155);
      #1;
      send = 1'b0;
      check("accept_ready", 32'(ready), 0);
      check("accept_tx", 32'(tx), 1);
      check("accept_busy", 32'(busy), 0);
      @(posedge clock);
      #1;
      check("start_tx", 32'(tx), 0);
      check("start_busy", 32'(busy), 1);
      check("start_ready", 32'(ready), 1);
      @(negedge clock);
      wait_idle(2 * FRAME);
      check("single_done_count", 32'(done_cyc.size()), 1);
      if (done_cyc.size() == 1 && start_cyc.size() == 1) begin
         check("single_done_offset", 32'(done_cyc[0] - start_cyc[0] + 1), 32'(FRAME));
         check("busy_fall", 32'(cyc - done_cyc[0]), 1);
      end
      repeat (20) @(negedge clock);
      check("idle_tx", 32'(tx), 1);

      // Back-to-back frames
      start_cyc.delete(); done_cyc.delete();
      send_word(9'h0FF);
      send_word(9'h100);
      wait_idle(3 * FRAME);
      check("b2b_done_count", 32'(done_cyc.size()), 2);
      if (done_cyc.size() == 2 && start_cyc.size() == 2) begin
         check("b2b_gap", 32'(start_cyc[1] - done_cyc[0]), 1);
         check("b2b_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(FRAME));
      end

      // Send while the holding register is full is ignored
      snap = frames_ok;
      send_word(9'h033);
      send_word(9'h0AA);
      send = 1'b1; data = 9'h1FF;
      repeat (5) @(negedge clock);
      check("full_ready", 32'(ready), 0);
      send = 1'b0;
      wait_idle(4 * FRAME);
      repeat (2 * DIV) @(negedge clock);
      check("full_frames", 32'(frames_ok - snap), 2);
      check("full_queue_empty", 32'(exp_q.size()), 0);

      // All-zero word (stop length follows the build configuration)
      start_cyc.delete(); done_cyc.delete();
      send_word(9'h000);
      wait_idle(2 * FRAME);
      check("zero_done_count", 32'(done_cyc.size()), 1);
      if (done_cyc.size() == 1 && start_cyc.size() == 1)
         check("zero_frame_len", 32'(done_cyc[0] - start_cyc[0] + 1), 32'(FRAME));

      // Reset during data bit 4, then a clean frame
      snap = frames_ok;
      send_word(9'h123);
      repeat (5 * DIV + 8) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_tx", 32'(tx), 1);
      check("midrst_ready", 32'(ready), 1);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("midrst_abandoned", 32'(frames_ok - snap), 0);
      send_word(9'h0C3);
      wait_idle(2 * FRAME);
      check("midrst_clean_frame", 32'(frames_ok - snap), 1);

      // Default divider: 25 MHz / 9600 truncates to 2604 cycles per bit
      @(negedge clock);
      big_send = 1'b1; big_data = 9'h155;
      @(negedge clock);
      big_send = 1'b0;
      k = 0;
      while (big_tx !== 1'b0 && k < 4) begin
         @(negedge clock);
         k++;
      end
      check("big_start_seen", 32'(big_tx), 0);
      for (int r = 0; r < 9; r++) begin
         len = 0;
         v = big_tx;
         do begin
            len++;
            @(negedge clock);
         end while (big_tx === v && len < 6000);
         check($sformatf("big_bit_len_%0d", r), 32'(len), 32'(BIG_DIV));
      end
      k = 0;
      while (big_done !== 1'b1 && k < 10000) begin
         @(negedge clock);
         k++;
      end
      check("big_done_offset", 32'(k), 32'(BIG_DIV * (1 + STOP_BITS) - 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the design's 9-bit UART receiver. Accepts a 9-bit word over a ready/send handshake and serialises it on `tx`. The frame is one start bit (0), nine data bits LSB first, and one stop bit (1). A one-entry holding register lets the next word be queued while the current frame is on the line, so back-to-back frames leave no idle gap. Bit timing comes from an internal divider; no external tick is used.

## Interface
- `CLK_HZ`, 25000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line bit rate; bit period `DIV = CLK_HZ/BAUD_RATE` clock cycles (integer truncation, 2604 at defaults; `DIV >= 2` required).
- `clock`  in  1  system clock, all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send`  in  1  request to transmit `data`; accepted on a rising edge when `send && ready`.
- `data`  in  9  word to transmit, captured on acceptance.
- `ready`  out  1  holding register empty; the block can accept a word.
- `busy`  out  1  a frame (start through last stop bit) is being driven.
- `done`  out  1  one-cycle pulse at the end of each frame's final stop bit.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- Holding register `hold[8:0]` plus `hold_valid`; `ready = !hold_valid`.
- `send && ready` at an edge: `hold <= data`, `hold_valid <= 1`.
- `send` while `!ready`: ignored. `data` is not captured and there is no error flag.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx=1`. If `hold_valid`, go to START, load `shift <= hold`, clear `hold_valid`, clear bit counter and baud counter.
- START: `tx=0` for DIV cycles, then go to DATA.
- DATA: `tx=shift[0]` for DIV cycles per bit. After each bit, shift right and increment the bit counter (4-bit, 0..8). After bit 8, go to STOP.
- STOP: `tx=1` for DIV cycles. At the last cycle, pulse `done`. Then:
  - if `hold_valid`, go directly to START and load `shift <= hold`, clear `hold_valid`;
  - otherwise go to IDLE.
- Baud counter: width `$clog2(DIV)`, counts 0..DIV-1, reset to 0 on every bit boundary.
- `busy` = 1 in START, DATA and STOP.
- Simultaneous acceptance and transfer, i.e. `send && ready` at the same edge the FSM takes `hold`: impossible, because `ready=0` whenever `hold_valid=1`. A `send` arriving at the edge after the transfer is accepted normally.
- Reset (any time, including mid-frame): `tx=1`, `ready=1`, `busy=0`, `done=0`, state IDLE, `hold_valid=0`, all counters 0. A partial frame is abandoned.

## Timing
- Acceptance at edge k: `ready` low after k. From edge k+1: state START, `tx=0`, `busy=1`, `ready=1`.
- Each bit is held for exactly DIV cycles; single-stop frame length is 11·DIV cycles.
- `done` is high for the single cycle that is the final cycle of the stop bit. `busy` stays 1 during that cycle.
- Back-to-back: the next start bit begins the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- Idle return: `tx` stays 1 and `busy` falls the cycle after `done`.

## Configuration
- `UART_TX_TWO_STOP_EN` defined: STOP lasts 2·DIV cycles; frame length is 12·DIV; `done` pulses at the last cycle of the second stop bit.
- Not defined: a single stop bit (DIV cycles); frame length is 11·DIV.
- Frames are valid for the 9-bit receiver either way.

## Test plan
- Single frame, `CLK_HZ=16`, `BAUD_RATE=1` (DIV=16), `data=9'h155` -> `tx` sequence 0, 1,0,1,0,1,0,1,0,1, 1, each bit held 16 cycles; `done` pulses once at cycle 176 after `tx` falls; `tx` idle high afterwards.
- Back-to-back: send `9'h0FF`, then `9'h100` while busy -> second `ready` drops; the second start bit begins the cycle after the first frame's last stop cycle; two `done` pulses 176 cycles apart.
- Send while full: queue `9'h0AA`, then assert `send` with `9'h1FF` while `ready=0` -> the second frame carries `9'h0AA`; `9'h1FF` never appears.
- Reset mid-frame: assert `reset_n=0` during data bit 4 -> `tx=1` immediately (asynchronous) and `ready=1`; after release a new `send` produces a clean full frame.
- Divider truncation: `CLK_HZ=25000000`, `BAUD_RATE=9600` -> each bit lasts exactly 2604 cycles.
- `UART_TX_TWO_STOP_EN` defined, DIV=16, `data=9'h000` -> nine 0 data bits, then 32 cycles of `tx=1` before `done`; frame length 192 cycles.
